rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares one N-input, WIDTH-bit mux datapath between N requesters using per-requester valid/ready handshakes. It picks one pending requester per cycle and drives the mux select from that grant. It registers the selected word together with its source index. It sits in front of any single-consumer resource that several producers must share.

---
 rtl/rr_mux_arbiter.sv | 112 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter in front of an N-input mux: grants one pending requester per cycle
// and registers the selected word with its source index behind a valid/ready output.
module rr_mux_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SEL_WIDTH = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_src,
    input  logic                 out_ready
);

    localparam logic [SEL_WIDTH:0]   NUM_REQ  = (SEL_WIDTH + 1)'(N);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N - 1);

    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_src_q, out_src_d;

    logic                 load;
    logic                 found;
    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 transfer;
    logic [WIDTH-1:0]     sel_word;
    logic [WIDTH-1:0]     req_word [N];

    assign load = !out_valid_q || out_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_word[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Search upward from ptr with explicit wrap so non-power-of-2 N never leaves 0..N-1.
    always_comb begin
        logic [SEL_WIDTH:0] cand;
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = {1'b0, ptr_q} + (SEL_WIDTH + 1)'(off);
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_valid[cand[SEL_WIDTH-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    // Reset gating keeps req_ready low while rst_n is held, even though load is high then.
    assign transfer = rst_n && load && found;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                sel_word = req_word[i];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
            out_src_d   = grant_idx;
            ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: the driver pushes hand-computed words, a monitor pops
// and compares whenever the consumer takes an output word.
module tb_rr_mux_arbiter;

    localparam int N = 8;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_src;
    logic             out_ready;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    rr_mux_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [7:0] val);
        req_data[i*WIDTH +: WIDTH] = val;
    endtask

    task automatic expect_word(input logic [2:0] src, input logic [7:0] data);
        exp_t e;
        e.src  = src;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: a word is consumed when out_valid && out_ready are both high mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {29'd0, out_src}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_src", {29'd0, out_src}, {29'd0, e.src});
                check("mon_data", {24'd0, out_data}, {24'd0, e.data});
            end
        end
    end

    logic [2:0] rot_src  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [7:0] rot_data [10] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                                  8'h10, 8'h11};
    logic [2:0] wrap_src  [3] = '{3'd0, 3'd2, 3'd0};
    logic [7:0] wrap_data [3] = '{8'hA0, 8'hA2, 8'hA0};

    initial begin
        // Reset state, with requests present to show req_ready is gated.
        rst_n     = 1'b0;
        req_valid = 8'hFF;
        req_data  = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_src", {29'd0, out_src}, 32'd0);
        check("rst_req_ready", {24'd0, req_ready}, 32'd0);
        cycle();
        check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        check("rst_hold_ready", {24'd0, req_ready}, 32'd0);

        // Single request from slot 3, then drain to empty.
        rst_n     = 1'b1;
        req_valid = 8'h08;
        set_slot(3, 8'h5A);
        #1;
        check("single_ready", {24'd0, req_ready}, 32'h08);
        expect_word(3'd3, 8'h5A);
        cycle();
        req_valid = 8'h00;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data", {24'd0, out_data}, 32'h5A);
        check("single_src", {29'd0, out_src}, 32'd3);
        cycle();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_data", {24'd0, out_data}, 32'h5A);

        // Grant to 5 (ptr 4 -> 6), then slots 0/2 must wrap and skip.
        req_valid = 8'h20;
        set_slot(5, 8'h55);
        #1;
        check("pre_wrap_ready", {24'd0, req_ready}, 32'h20);
        expect_word(3'd5, 8'h55);
        cycle();
        req_valid = 8'h05;
        set_slot(0, 8'hA0);
        set_slot(2, 8'hA2);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wrap_ready", {24'd0, req_ready}, 32'd1 << wrap_src[i]);
            expect_word(wrap_src[i], wrap_data[i]);
            cycle();
        end

        // Back-pressure: hold src 2 while slots 4/5 wait.
        req_valid = 8'h04;
        set_slot(2, 8'hB2);
        #1;
        check("bp_load_ready", {24'd0, req_ready}, 32'h04);
        expect_word(3'd2, 8'hB2);
        cycle();
        out_ready = 1'b0;
        req_valid = 8'h30;
        set_slot(4, 8'hC4);
        set_slot(5, 8'hC5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", {24'd0, req_ready}, 32'd0);
            check("bp_data", {24'd0, out_data}, 32'hB2);
            check("bp_src", {29'd0, out_src}, 32'd2);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            cycle();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {24'd0, req_ready}, 32'h10);
        expect_word(3'd4, 8'hC4);
        cycle();
        req_valid = 8'h20;
        check("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
        check("bp_no_bubble_src", {29'd0, out_src}, 32'd4);
        #1;
        check("bp_next_ready", {24'd0, req_ready}, 32'h20);
        expect_word(3'd5, 8'hC5);
        cycle();
        req_valid = 8'h00;
        cycle();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);

        // Reset pulse between edges brings ptr back to 0 before the rotation.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cycle();

        // Rotation with all requesters valid.
        req_valid = 8'hFF;
        for (int i = 0; i < N; i++) begin
            set_slot(i, 8'h10 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            #1;
            check("rot_ready", {24'd0, req_ready}, 32'd1 << rot_src[i]);
            expect_word(rot_src[i], rot_data[i]);
            cycle();
        end

        // Asynchronous reset mid-burst discards the registered word.
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_ready", {24'd0, req_ready}, 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {24'd0, req_ready}, 32'h01);
        expect_word(3'd0, 8'h10);
        cycle();
        req_valid = 8'h00;
        check("post_rst_src", {29'd0, out_src}, 32'd0);
        check("post_rst_data", {24'd0, out_data}, 32'h10);
        cycle();
        check("final_drain_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
